// File: rtl/fetch_instr_buffer_if.sv
// Fetch-to-decode bus used by fetch_instr_buffer.
// Signals:
//   in_valid, in_mask, in_pc, in_instr, in_guesses_branch, in_prediction:
//     the fetch group from the front end (lane 0 = oldest).
//   in_ready: the buffer can take a full group this cycle.
//   out_valid, out_pc, out_instr, out_guesses_branch, out_prediction:
//     decode lanes; out_valid is thermometer-coded.
//   out_ready: decode consumes every valid lane this cycle.
// Modports:
//   master - front end plus decode side, which drives in_* and out_ready.
//   slave  - the buffer itself.
interface fetch_instr_buffer_if #(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned DEC_WIDTH   = 2,
  parameter int unsigned ADDR_WIDTH  = 32
);
  logic                              in_valid;
  logic [FETCH_WIDTH-1:0]            in_mask;
  logic [FETCH_WIDTH*ADDR_WIDTH-1:0] in_pc;
  logic [FETCH_WIDTH*32-1:0]         in_instr;
  logic [FETCH_WIDTH-1:0]            in_guesses_branch;
  logic [FETCH_WIDTH*ADDR_WIDTH-1:0] in_prediction;
  logic                              in_ready;

  logic [DEC_WIDTH-1:0]              out_valid;
  logic [DEC_WIDTH*ADDR_WIDTH-1:0]   out_pc;
  logic [DEC_WIDTH*32-1:0]           out_instr;
  logic [DEC_WIDTH-1:0]              out_guesses_branch;
  logic [DEC_WIDTH*ADDR_WIDTH-1:0]   out_prediction;
  logic                              out_ready;

  modport master (
    output in_valid, in_mask, in_pc, in_instr, in_guesses_branch, in_prediction,
    output out_ready,
    input  in_ready,
    input  out_valid, out_pc, out_instr, out_guesses_branch, out_prediction
  );

  modport slave (
    input  in_valid, in_mask, in_pc, in_instr, in_guesses_branch, in_prediction,
    input  out_ready,
    output in_ready,
    output out_valid, out_pc, out_instr, out_guesses_branch, out_prediction
  );
endinterface

// File: rtl/fetch_instr_buffer.sv
// Decoupling queue between the I-cache/predictor front end and decode.
// Takes fetch groups of up to FETCH_WIDTH instructions with an arbitrary lane
// mask, compacts the set lanes in program order into a circular store of DEPTH
// entries, and presents up to DEC_WIDTH of the oldest entries to decode.
// Ports:
//   clk   - clock
//   reset - synchronous, active-high; empties the queue (storage not cleared)
//   flush - empties the queue and drops the same-cycle input group
//   bus   - fetch_instr_buffer_if.slave (fetch group in, decode lanes out)
//   count - registered occupancy, 0..DEPTH
module fetch_instr_buffer #(
  parameter  int unsigned FETCH_WIDTH = 2,
  parameter  int unsigned DEC_WIDTH   = 2,
  parameter  int unsigned DEPTH       = 8,
  parameter  int unsigned ADDR_WIDTH  = 32,
  localparam int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  fetch_instr_buffer_if.slave   bus,
  output logic [CNT_W-1:0]      count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [31:0]           instr_mem[DEPTH];
  logic                  gb_mem   [DEPTH];
  logic [ADDR_WIDTH-1:0] pred_mem [DEPTH];

  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;

  logic             in_ready_int;
  logic             push_en;
  logic [CNT_W-1:0] push_cnt;
  logic [CNT_W-1:0] pop_cnt;
  logic [PTR_W-1:0] wr_idx[FETCH_WIDTH];
  logic [PTR_W-1:0] rd_idx[DEC_WIDTH];

  // Based on registered count only: same-cycle pops are not credited, which
  // keeps out_ready off the in_ready path.
  assign in_ready_int = (count_q <= CNT_W'(DEPTH - FETCH_WIDTH));
  assign bus.in_ready = in_ready_int;
  assign count        = count_q;

  // Compaction: each set lane goes to tail plus the number of set lanes
  // below it, so skipped lanes leave no holes.
  always_comb begin
    push_en  = bus.in_valid && in_ready_int && !flush && !reset;
    push_cnt = '0;
    for (int unsigned l = 0; l < FETCH_WIDTH; l++) begin
      wr_idx[l] = tail_q + PTR_W'(push_cnt);
      if (bus.in_mask[l]) push_cnt = push_cnt + CNT_W'(1);
    end
    if (!push_en) push_cnt = '0;

    pop_cnt = '0;
    if (bus.out_ready)
      pop_cnt = (count_q < CNT_W'(DEC_WIDTH)) ? count_q : CNT_W'(DEC_WIDTH);
  end

  always_comb begin
    bus.out_valid          = '0;
    bus.out_pc             = '0;
    bus.out_instr          = '0;
    bus.out_guesses_branch = '0;
    bus.out_prediction     = '0;
    for (int unsigned i = 0; i < DEC_WIDTH; i++) begin
      rd_idx[i]                                     = head_q + PTR_W'(i);
      bus.out_valid[i]                              = (count_q > CNT_W'(i));
      bus.out_pc[i*ADDR_WIDTH +: ADDR_WIDTH]         = pc_mem[rd_idx[i]];
      bus.out_instr[i*32 +: 32]                     = instr_mem[rd_idx[i]];
      bus.out_guesses_branch[i]                     = gb_mem[rd_idx[i]];
      bus.out_prediction[i*ADDR_WIDTH +: ADDR_WIDTH] = pred_mem[rd_idx[i]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PTR_W'(pop_cnt);
      tail_q  <= tail_q + PTR_W'(push_cnt);
      count_q <= count_q + push_cnt - pop_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      for (int unsigned l = 0; l < FETCH_WIDTH; l++) begin
        if (bus.in_mask[l]) begin
          pc_mem[wr_idx[l]]    <= bus.in_pc[l*ADDR_WIDTH +: ADDR_WIDTH];
          instr_mem[wr_idx[l]] <= bus.in_instr[l*32 +: 32];
          gb_mem[wr_idx[l]]    <= bus.in_guesses_branch[l];
          pred_mem[wr_idx[l]]  <= bus.in_prediction[l*ADDR_WIDTH +: ADDR_WIDTH];
        end
      end
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    int'(count_q) <= int'(DEPTH));

  a_out_valid_thermo: assert property (@(posedge clk) disable iff (reset)
    (bus.out_valid & (bus.out_valid + DEC_WIDTH'(1))) == '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    int'(count_q) + int'(push_cnt) <= int'(DEPTH));

endmodule
